// File: rtl/mantissa_sub_norm_24_if.sv
// rtl/mantissa_sub_norm_24_if.sv - start/done bundle for the mantissa subtract-and-normalize unit
interface mantissa_sub_norm_24_if #(
    parameter int N  = 24,
    parameter int CW = 5
);
    logic          start;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          busy;
    logic          done;
    logic [N-1:0]  result;
    logic [CW-1:0] shift_cnt;
    logic          sign;
    logic          zero;

    modport master (
        output start, a, b,
        input  busy, done, result, shift_cnt, sign, zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, result, shift_cnt, sign, zero
    );
endinterface

// File: rtl/mantissa_sub_norm_24.sv
// rtl/mantissa_sub_norm_24.sv - |a - b| with sign, then left-normalize one bit per cycle
module mantissa_sub_norm_24 #(
    parameter int N  = 24,
    parameter int CW = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    mantissa_sub_norm_24_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SUB, NORM, DONE} state_t;

    state_t        state;
    logic [N-1:0]  opa;
    logic [N-1:0]  opb;
    logic [N-1:0]  diff;
    logic [N-1:0]  result_r;
    logic [CW-1:0] cnt_r;
    logic          sign_r;
    logic          zero_r;
    logic          busy_r;
    logic          done_r;
    logic [N:0]    sub_full;

    // One extra bit so the borrow out of the N-bit subtract selects the operand order.
    assign sub_full = {1'b0, opa} - {1'b0, opb};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            opa      <= '0;
            opb      <= '0;
            diff     <= '0;
            result_r <= '0;
            cnt_r    <= '0;
            sign_r   <= 1'b0;
            zero_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        opa    <= bus.a;
                        opb    <= bus.b;
                        busy_r <= 1'b1;
                        state  <= SUB;
                    end
                end
                SUB: begin
                    if (sub_full[N]) begin
                        sign_r <= 1'b1;
                        diff   <= opb - opa;
                    end else begin
                        sign_r <= 1'b0;
                        diff   <= sub_full[N-1:0];
                    end
                    zero_r <= (opa == opb);
                    cnt_r  <= '0;
                    state  <= NORM;
                end
                NORM: begin
                    // A zero difference can never normalize, so it exits unshifted.
                    if (diff[N-1] || (diff == '0)) begin
                        result_r <= diff;
                        done_r   <= 1'b1;
                        state    <= DONE;
                    end else begin
                        diff  <= {diff[N-2:0], 1'b0};
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.result    = result_r;
    assign bus.shift_cnt = cnt_r;
    assign bus.sign      = sign_r;
    assign bus.zero      = zero_r;
endmodule

// File: tb/tb_mantissa_sub_norm_24.sv
// tb/tb_mantissa_sub_norm_24.sv - scoreboard bench for mantissa_sub_norm_24
module tb_mantissa_sub_norm_24;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mantissa_sub_norm_24_if #(.N(24), .CW(5)) bus ();

    mantissa_sub_norm_24 #(.N(24), .CW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [23:0] result;
        logic [4:0]  cnt;
        logic        sign;
        logic        zero;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];

    logic [23:0] h_result = '0;
    logic [4:0]  h_cnt    = '0;
    logic        h_sign   = 1'b0;
    logic        h_zero   = 1'b0;

    function automatic exp_t model(input logic [23:0] a, input logic [23:0] b, input int acc_cyc);
        exp_t e;
        int unsigned ia = a;
        int unsigned ib = b;
        int unsigned d;
        int k = 0;
        d = (ia >= ib) ? ia - ib : ib - ia;
        if (d != 0)
            while (d < 32'h0080_0000) begin
                d = d * 2;
                k++;
            end
        e.result   = d[23:0];
        e.cnt      = k[4:0];
        e.sign     = (ia < ib);
        e.zero     = (ia == ib);
        e.done_cyc = acc_cyc + k + 2;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: all comparisons and the scoreboard pops live here.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                sb.delete();
                h_result = '0; h_cnt = '0; h_sign = 1'b0; h_zero = 1'b0;
                #1;
                chk("rst_busy",   {31'd0, bus.busy}, 32'd0);
                chk("rst_done",   {31'd0, bus.done}, 32'd0);
                chk("rst_result", {8'd0, bus.result}, 32'd0);
                chk("rst_cnt",    {27'd0, bus.shift_cnt}, 32'd0);
                chk("rst_sign",   {31'd0, bus.sign}, 32'd0);
                chk("rst_zero",   {31'd0, bus.zero}, 32'd0);
            end else if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("result",    {8'd0, bus.result}, {8'd0, e.result});
                    chk("shift_cnt", {27'd0, bus.shift_cnt}, {27'd0, e.cnt});
                    chk("sign",      {31'd0, bus.sign}, {31'd0, e.sign});
                    chk("zero",      {31'd0, bus.zero}, {31'd0, e.zero});
                    chk("latency",   cyc, e.done_cyc);
                    chk("busy_in_done", {31'd0, bus.busy}, 32'd1);
                    h_result = e.result; h_cnt = e.cnt; h_sign = e.sign; h_zero = e.zero;
                end
            end else begin
                if (!bus.busy)
                    chk("held_outputs", {bus.result, bus.shift_cnt, bus.sign, bus.zero},
                        {h_result, h_cnt, h_sign, h_zero});
                if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
                    chk("done_timeout", cyc, sb[0].done_cyc);
                    void'(sb.pop_front());
                end
            end
        end
    end

    function automatic logic [23:0] near(input logic [23:0] a);
        int unsigned w = $urandom_range(0, 24);
        int unsigned m = (w == 0) ? 0 : ((32'd1 << w) - 1);
        int unsigned delta = $urandom & m;
        return ($urandom_range(0, 1) == 1) ? a + delta[23:0] : a - delta[23:0];
    endfunction

    task automatic issue(input logic [23:0] a, input logic [23:0] b);
        for (int i = 0; i < 40 && bus.busy; i++) @(negedge clk);
        if (!bus.busy) begin
            bus.a = a;
            bus.b = b;
            bus.start = 1'b1;
            sb.push_back(model(a, b, cyc + 1));
            @(negedge clk);
            bus.start = 1'b0;
            bus.a = $urandom;
            bus.b = $urandom;
        end
    endtask

    initial begin
        logic [23:0] ra;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(24'h800000, 24'h400000);
        issue(24'h400000, 24'h800000);
        issue(24'hABCDEF, 24'hABCDEF);
        issue(24'h000001, 24'h000000);

        // Abort a long normalization part-way through.
        issue(24'h000001, 24'h000000);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(24'hFFFFFF, 24'h7FFFFF);

        for (int n = 0; n < 30; n++) begin
            ra = $urandom;
            issue(ra, near(ra));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Start held high with operands changing every cycle.
        for (int n = 0; n < 150; n++) begin
            ra = $urandom;
            bus.a = ra;
            bus.b = near(ra);
            bus.start = 1'b1;
            if (!bus.busy) sb.push_back(model(bus.a, bus.b, cyc + 1));
            @(negedge clk);
        end
        bus.start = 1'b0;

        repeat (40) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
